// File: rtl/barrett_constant_gen.sv
// Barrett reduction constant generator.
// For a modulus m it produces the shift amount R = 2k and the multiplier
// floor(2^(2k)/m). k is the bit length of m. The division is a restoring
// long division that handles one dividend bit per cycle.
module barrett_constant_gen #(
  parameter int WIDTH = 32
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   denominator,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   R,
  output logic [WIDTH+1:0]   constant
);

  localparam int KW = $clog2(WIDTH + 1);      // holds k in 1..WIDTH
  localparam int CW = $clog2(2 * WIDTH + 2);  // holds 2k+1

  typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   m_q;
  logic [KW-1:0]      k_q;
  logic [CW-1:0]      cnt_q;
  logic               first_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH+1:0]   quo_q;
  logic               done_q;
  logic               err_q;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH+1:0]   const_q;

  logic [KW-1:0]      k_d;
  logic [WIDTH:0]     rem_sh;
  logic               q_bit;
  logic [WIDTH:0]     rem_d;
  logic [WIDTH+1:0]   quo_d;

  // Priority encode: bit length of the latched modulus (0 when m is 0).
  always_comb begin
    k_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (m_q[i]) k_d = KW'(i + 1);
    end
  end

  // One restoring-division step. The dividend is 1 followed by 2k zeros, so
  // the bit shifted in is 1 only on the first iteration. The remainder stays
  // below m, so WIDTH+1 bits can hold the shifted value without overflow.
  always_comb begin
    rem_sh = (rem_q << 1) | {{WIDTH{1'b0}}, first_q};
    q_bit  = (rem_sh >= {1'b0, m_q});
    rem_d  = q_bit ? (rem_sh - {1'b0, m_q}) : rem_sh;
    quo_d  = (quo_q << 1) | {{(WIDTH+1){1'b0}}, q_bit};
  end

  // Control FSM and datapath. Results are loaded on the edge that enters
  // DONE, so they are valid in the same cycle that done is high.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      r_q     <= '0;
      const_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q     <= denominator;
            state_q <= NORM;
          end
        end
        NORM: begin
          k_q     <= k_d;
          rem_q   <= '0;
          quo_q   <= '0;
          first_q <= 1'b1;
          if (m_q == '0) begin
            err_q   <= 1'b1;
            r_q     <= '0;
            const_q <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q   <= CW'({k_d, 1'b0}) + CW'(1);
            state_q <= DIV;
          end
        end
        DIV: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          first_q <= 1'b0;
          cnt_q   <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            r_q     <= WIDTH'({k_q, 1'b0});
            const_q <= quo_d;
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign R        = r_q;
  assign constant = const_q;

endmodule

// File: tb/tb_barrett_constant_gen.sv
// Scoreboard bench for barrett_constant_gen (WIDTH=32). The driver pushes
// hand-computed expected results; a monitor pops and compares on each done.
module tb_barrett_constant_gen;

  localparam int W = 32;

  logic           sys_clk = 1'b0;
  logic           sys_rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   denominator = '0;
  logic           busy, done, err;
  logic [W-1:0]   R;
  logic [W+1:0]   constant;

  barrett_constant_gen #(.WIDTH(W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .denominator(denominator), .busy(busy), .done(done), .err(err),
    .R(R), .constant(constant)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [W-1:0] r;
    logic [W+1:0] c;
    logic         e;
    int           lat;
    int           c0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge sys_clk) begin
    if (!sys_rst && done) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: done=1 with no request pending (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("R", 64'(R), 64'(e.r));
        chk("constant", 64'(constant), 64'(e.c));
        chk("err", 64'(err), 64'(e.e));
        chk("latency", 64'(cyc - e.c0), 64'(e.lat));
      end
    end
  end

  // Wait for IDLE (bounded), then present one request for a single cycle.
  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] r,
                       input logic [W+1:0] c, input logic e, input int lat,
                       input bit push);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (busy && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    if (busy) begin
      n_total++;
      $display("FAIL idle_timeout: busy stuck at 1, expected 0");
    end
    start = 1'b1;
    denominator = m;
    if (push) sb.push_back('{r: r, c: c, e: e, lat: lat, c0: cyc});
    @(negedge sys_clk);
    chk("busy_after_accept", 64'(busy), 64'd1);
    start = 1'b0;
    denominator = $urandom;  // must not affect the operation in flight
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_R", 64'(R), 64'd0);
    chk("rst_const", 64'(constant), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    //     m              R    constant            err lat
    issue(32'd7,          6,   34'd9,              0,  9,  1);
    issue(32'd1,          2,   34'd4,              0,  5,  1);
    issue(32'd3,          4,   34'd5,              0,  7,  1);
    issue(32'd5,          6,   34'd12,             0,  9,  1);
    issue(32'h0001_0000,  34,  34'h0_0004_0000,    0,  37, 1);
    issue(32'hFFFF_FFFF,  64,  34'h1_0000_0001,    0,  67, 1);
    issue(32'h8000_0000,  64,  34'h2_0000_0000,    0,  67, 1);
    issue(32'd0,          0,   34'd0,              1,  2,  1);
    issue(32'd7,          6,   34'd9,              0,  9,  1);

    // A start with m=3 while m=7 is busy must be ignored.
    issue(32'd7,          6,   34'd9,              0,  9,  1);
    @(negedge sys_clk);
    start = 1'b1;
    denominator = 32'd3;
    @(negedge sys_clk);
    start = 1'b0;

    // Reset in the middle of an m=7 run: outputs clear at once, no done.
    issue(32'd7, 6, 34'd9, 0, 9, 0);
    repeat (3) @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_R", 64'(R), 64'd0);
    chk("midrst_const", 64'(constant), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (15) @(negedge sys_clk);
    chk("post_rst_idle", 64'(busy), 64'd0);

    // First request after reset is accepted normally.
    issue(32'd7,          6,   34'd9,              0,  9,  1);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge sys_clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    repeat (3) @(negedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
